// File: rtl/pwm_peripheral.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_peripheral                                                           |
// | Drives 16 user outputs: static high or one shared double-buffered PWM.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] en_out,
  input  logic [15:0] pwm_mode,
  input  logic [7:0]  duty,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] C_PRE_LAST = 16'(CLK_DIV - 1);

  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_sh_q, duty_sh_d;
  logic [15:0] out_q, out_d;
  logic        period_start_q;

  logic        tick;
  logic        wrap;
  logic        pwm_raw;

  assign tick = (pre_cnt_q == C_PRE_LAST);
  assign wrap = tick && (pwm_cnt_q == 8'hFF);

  // Full-scale duty is forced high so 0xFF means "always on", not 255/256.
  assign pwm_raw = (duty_sh_q == 8'hFF) || (pwm_cnt_q < duty_sh_q);

  always_comb begin
    pre_cnt_d = pre_cnt_q + 16'd1;
    pwm_cnt_d = pwm_cnt_q;
    duty_sh_d = duty_sh_q;
    if (tick) begin
      pre_cnt_d = 16'd0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end
    if (wrap) begin
      duty_sh_d = duty;
    end
    out_d = en_out & (~pwm_mode | {16{pwm_raw}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q      <= 16'd0;
      pwm_cnt_q      <= 8'd0;
      duty_sh_q      <= 8'd0;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_sh_q      <= duty_sh_d;
      out_q          <= out_d;
      period_start_q <= wrap;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_peripheral                                                        |
// | Directed self-checking bench for pwm_peripheral with CLK_DIV = 4.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pwm_peripheral;

  localparam int unsigned CLK_DIV = 4;
  localparam int PERIOD = 256 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out = 16'h0000;
  logic [15:0] pwm_mode = 16'h0000;
  logic [7:0]  duty = 8'h00;
  logic [15:0] out;
  logic        period_start;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_out       (en_out),
    .pwm_mode     (pwm_mode),
    .duty         (duty),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until period_start is seen; counts cycles and nonzero-out samples.
  task automatic wait_ps(output int cycles, output int nonzero);
    cycles  = -1;
    nonzero = 0;
    for (int i = 1; i <= PERIOD + 64; i++) begin
      step();
      if (out != 16'h0000) nonzero++;
      if (period_start) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Observes one full period starting from a period_start sample.
  task automatic measure(input int bit_idx, input logic [15:0] smask,
                         input logic [15:0] sval, input int chg_at,
                         input logic [7:0] chg_val,
                         output int ones, output int gap, output int bad);
    ones = 0;
    gap  = 0;
    bad  = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      if (i == chg_at) duty = chg_val;
      step();
      if (out[bit_idx]) ones++;
      if (period_start && gap == 0) gap = i;
      if ((out & smask) != sval) bad++;
    end
  endtask

  initial begin
    int cyc, nz, ones, gap, bad;

    // Reset state
    en_out   = 16'h0001;
    pwm_mode = 16'h0001;
    duty     = 8'h80;
    repeat (3) step();
    chk("reset_out", 32'(out), 32'h0000);
    chk("reset_ps", 32'(period_start), 32'h0);
    rst_n = 1'b1;

    // First period runs at duty 0; period_start 1024 cycles after release
    wait_ps(cyc, nz);
    chk("first_ps_cycles", 32'(cyc), 32'd1024);
    chk("first_period_low", 32'(nz), 32'd0);

    measure(0, 16'hFFFE, 16'h0000, 0, 8'h00, ones, gap, bad);
    chk("duty80_high", 32'(ones), 32'd512);
    chk("duty80_gap", 32'(gap), 32'd1024);
    chk("duty80_upper_zero", 32'(bad), 32'd0);

    // Duty written mid-period only takes effect at the next boundary
    duty = 8'h00;
    measure(0, 16'hFFFE, 16'h0000, 0, 8'h00, ones, gap, bad);
    chk("duty80_retained", 32'(ones), 32'd512);
    duty = 8'hFF;
    measure(0, 16'hFFFE, 16'h0000, 0, 8'h00, ones, gap, bad);
    chk("duty00_const0", 32'(ones), 32'd0);
    duty = 8'h40;
    measure(0, 16'hFFFE, 16'h0000, 0, 8'h00, ones, gap, bad);
    chk("dutyFF_const1", 32'(ones), 32'd1024);
    measure(0, 16'hFFFE, 16'h0000, 100, 8'hC0, ones, gap, bad);
    chk("duty40_midchange", 32'(ones), 32'd256);
    measure(0, 16'hFFFE, 16'h0000, 0, 8'h00, ones, gap, bad);
    chk("dutyC0_next", 32'(ones), 32'd768);

    // Static outputs respond one cycle later
    en_out   = 16'hFFFF;
    pwm_mode = 16'h0000;
    step();
    chk("static_ffff", 32'(out), 32'h0000FFFF);
    en_out = 16'h00F0;
    step();
    chk("static_00f0", 32'(out), 32'h000000F0);

    // Mixed static/PWM
    en_out   = 16'hAAAA;
    pwm_mode = 16'hFF00;
    duty     = 8'h20;
    wait_ps(cyc, nz);
    chk("mixed_ps_seen", 32'(cyc > 0), 32'd1);
    measure(9, 16'h55FF, 16'h00AA, 0, 8'h00, ones, gap, bad);
    chk("mixed_bit9_high", 32'(ones), 32'd128);
    chk("mixed_static_bits", 32'(bad), 32'd0);
    measure(15, 16'h55FF, 16'h00AA, 0, 8'h00, ones, gap, bad);
    chk("mixed_bit15_high", 32'(ones), 32'd128);

    // Reset mid-high-phase
    repeat (20) step();
    chk("pre_reset_high", 32'(out), 32'h0000AAAA);
    pwm_mode = 16'hFFFF;
    rst_n    = 1'b0;
    #1;
    chk("async_reset_out", 32'(out), 32'h0000);
    chk("async_reset_ps", 32'(period_start), 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    wait_ps(cyc, nz);
    chk("post_reset_ps_cycles", 32'(cyc), 32'd1024);
    chk("post_reset_low", 32'(nz), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
